// File: rtl/clc_key_if.sv
// Operand/result bundle between the key-exchange controller and clc_key.
// The master drives the request and operands; the slave returns key and status.
interface clc_key_if #(
    parameter int W = 32
);
    logic         st;
    logic [W-1:0] r;
    logic [W-1:0] x;
    logic [W-1:0] p;
    logic [W-1:0] key;
    logic         busy;
    logic         done;
    logic         err;

    modport master (output st, r, x, p, input key, busy, done, err);
    modport slave  (input st, r, x, p, output key, busy, done, err);
endinterface

// File: rtl/clc_key.sv
// Shared-secret engine: key = r^x mod p using constant-time left-to-right
// square-and-multiply over a bit-serial interleaved modular multiplier.
module clc_key #(
    parameter int W = 32
) (
    input  logic     clk,
    input  logic     rst,
    clc_key_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_r;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_p;
    logic [W-1:0]  r_base;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_key;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_idx;

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [W:0]    w_dbl;
    logic [W:0]    w_t;
    logic [W:0]    w_sum;
    logic [W:0]    w_red;
    logic [W-1:0]  w_mm;
    logic          w_last;
    logic          w_busy;
    logic          w_done;

    assign w_last = (r_cnt == '0);

    // One multiplier step; both sums stay below 2p, so W+1 bits hold them.
    always_comb begin
        w_a = r_res;
        w_b = r_res;
        case (r_state)
            S_REDUCE: begin
                w_a = r_r;
                w_b = W'(1);
            end
            S_MUL:   w_b = r_base;
            default: ;
        endcase
        w_dbl = {r_acc, 1'b0};
        w_t   = (w_dbl >= {1'b0, r_p}) ? (w_dbl - {1'b0, r_p}) : w_dbl;
        w_sum = w_t + (w_a[r_cnt] ? {1'b0, w_b} : '0);
        w_red = (w_sum >= {1'b0, r_p}) ? (w_sum - {1'b0, r_p}) : w_sum;
        w_mm  = w_red[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.st) w_next = (bus.p == '0) ? S_DONE : S_REDUCE;
            S_REDUCE: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_SQR;
            end
            S_SQR: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_MUL;
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (w_last) w_next = (r_idx == '0) ? S_DONE : S_SQR;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r    <= '0;
            r_x    <= '0;
            r_p    <= '0;
            r_base <= '0;
            r_res  <= '0;
            r_acc  <= '0;
            r_key  <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.st) begin
                    r_r   <= bus.r;
                    r_x   <= bus.x;
                    r_p   <= bus.p;
                    r_acc <= '0;
                    r_cnt <= CW'(W - 1);
                    r_idx <= CW'(W - 1);
                    r_res <= (bus.p == W'(1)) ? '0 : W'(1);
                    r_key <= '0;
                    r_err <= (bus.p == '0);
                end
                S_REDUCE, S_SQR, S_MUL: begin
                    r_acc <= w_last ? '0 : w_mm;
                    r_cnt <= w_last ? CW'(W - 1) : (r_cnt - CW'(1));
                    if (w_last) begin
                        case (r_state)
                            S_REDUCE: r_base <= w_mm;
                            S_SQR:    r_res  <= w_mm;
                            default: begin
                                // Multiply always runs; x[i] only selects whether it is kept.
                                if (r_x[r_idx]) r_res <= w_mm;
                                if (r_idx == '0) r_key <= r_x[r_idx] ? w_mm : r_res;
                                else             r_idx <= r_idx - CW'(1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.key  = r_key;
    assign bus.err  = r_err;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
endmodule

// File: tb/tb_clc_key.sv
// Directed bench for clc_key: vector table of modular exponentiations plus
// hand-written protocol, held-start and mid-run reset sequences.
module tb_clc_key;
    localparam int W   = 32;
    localparam int LAT = W + 2 * W * W;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] x;
        logic [W-1:0] p;
        logic [W-1:0] key;
        logic         err;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[12];

    clc_key_if #(.W(W)) bus ();
    clc_key #(.W(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic kick(input logic [W-1:0] r, input logic [W-1:0] x, input logic [W-1:0] p);
        @(negedge clk);
        bus.r  = r;
        bus.x  = x;
        bus.p  = p;
        bus.st = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the st edge; counts edges until done is seen.
    task automatic wait_done(input string name, input logic [W-1:0] ek, input logic ee,
                             input int elat, input bit release_st, input int disturb_at);
        int n = 0;
        #1;
        if (release_st) bus.st = 1'b0;
        check({name, " busy_after_st"}, W'(bus.busy), W'(elat != 0));
        while (!bus.done && n < LAT + 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == disturb_at) begin
                bus.st = 1'b1;
                bus.r  = $urandom;
                bus.x  = $urandom;
                bus.p  = $urandom;
            end
            if (n == disturb_at + 1) bus.st = 1'b0;
        end
        check({name, " latency"}, W'(n), W'(elat));
        check({name, " key"}, bus.key, ek);
        check({name, " err"}, W'(bus.err), W'(ee));
        @(posedge clk);
        #1;
        check({name, " done_pulse_end"}, W'(bus.done), '0);
        check({name, " key_held"}, bus.key, ek);
        check({name, " err_held"}, W'(bus.err), W'(ee));
        check({name, " busy_idle"}, W'(bus.busy), '0);
    endtask

    initial begin
        int seen;
        vt[0]  = '{32'd3,        32'd6,  32'd5,        32'd4,  1'b0, "basic"};
        vt[1]  = '{32'd4,        32'd3,  32'd5,        32'd4,  1'b0, "peer"};
        vt[2]  = '{32'd23,       32'd2,  32'd7,        32'd4,  1'b0, "reduce"};
        vt[3]  = '{32'hFFFFFFFF, 32'd2,  32'hFFFFFFFB, 32'd16, 1'b0, "carry"};
        vt[4]  = '{32'd5,        32'd0,  32'd11,       32'd1,  1'b0, "x_zero"};
        vt[5]  = '{32'd9,        32'd5,  32'd1,        32'd0,  1'b0, "p_one"};
        vt[6]  = '{32'd7,        32'd3,  32'd0,        32'd0,  1'b1, "p_zero"};
        vt[7]  = '{32'd0,        32'd5,  32'd13,       32'd0,  1'b0, "r_zero"};
        vt[8]  = '{32'd2,        32'd10, 32'd1000,     32'd24, 1'b0, "pow2_10"};
        vt[9]  = '{32'd2,        32'd31, 32'h7FFFFFFF, 32'd1,  1'b0, "mersenne"};
        vt[10] = '{32'd3,        32'd0,  32'd1,        32'd0,  1'b0, "x0_p1"};
        vt[11] = '{32'd6,        32'd2,  32'd0,        32'd0,  1'b1, "p_zero2"};

        bus.st = 1'b0;
        bus.r  = '0;
        bus.x  = '0;
        bus.p  = '0;
        #2 rst = 1'b0;
        #1;
        check("reset key", bus.key, '0);
        check("reset busy", W'(bus.busy), '0);
        check("reset done", W'(bus.done), '0);
        check("reset err", W'(bus.err), '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            kick(vt[i].r, vt[i].x, vt[i].p);
            wait_done(vt[i].name, vt[i].key, vt[i].err, vt[i].err ? 0 : LAT, 1'b1, -1);
        end

        // st pulse and operand changes mid-run are ignored
        kick(32'd3, 32'd6, 32'd5);
        wait_done("midrun_st", 32'd4, 1'b0, LAT, 1'b1, 100);

        // st held across done: second run accepted in the IDLE cycle after done
        kick(32'd3, 32'd6, 32'd5);
        wait_done("hold_first", 32'd4, 1'b0, LAT, 1'b0, -1);
        bus.r = 32'd2;
        bus.x = 32'd10;
        bus.p = 32'd1000;
        @(posedge clk);
        wait_done("hold_second", 32'd24, 1'b0, LAT, 1'b1, -1);

        // reset mid-operation
        kick(32'd2, 32'd10, 32'd1000);
        #1 bus.st = 1'b0;
        repeat (499) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst key", bus.key, '0);
        check("midrst busy", W'(bus.busy), '0);
        check("midrst done", W'(bus.done), '0);
        check("midrst err", W'(bus.err), '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (LAT + 50) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("midrst no_done", W'(seen), '0);
        check("midrst idle_busy", W'(bus.busy), '0);
        kick(32'd3, 32'd6, 32'd5);
        wait_done("after_rst", 32'd4, 1'b0, LAT, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
